// File: rtl/parking_log_ctrl.sv
// Circular 8-entry occupancy log in an external RAM: logs samples, streams them
// back oldest-first on request, and zero-fills the RAM on clear.
module parking_log_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              log_req,
    input  logic [DATA_W-1:0] log_data,
    input  logic              scan_start,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic [ADDR_W-1:0] scan_idx,
    output logic              scan_done,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              log_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W:0]     scan_n_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [DATA_W-1:0]   wr_data_reg;
    logic                wr_en_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic                scan_valid_reg;
    logic [DATA_W-1:0]   scan_data_reg;
    logic [ADDR_W-1:0]   scan_idx_reg;
    logic                scan_done_reg;
    logic                busy_reg;
    logic                log_drop_reg;

    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign wr_en      = wr_en_reg;
    assign rd_addr    = rd_addr_reg;
    assign scan_valid = scan_valid_reg;
    assign scan_data  = scan_data_reg;
    assign scan_idx   = scan_idx_reg;
    assign scan_done  = scan_done_reg;
    assign count      = count_reg;
    assign full       = (count_reg == CNT_MAX);
    assign busy       = busy_reg;
    assign log_drop   = log_drop_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            scan_n_reg     <= '0;
            idx_reg        <= '0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            wr_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            scan_valid_reg <= 1'b0;
            scan_data_reg  <= '0;
            scan_idx_reg   <= '0;
            scan_done_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            log_drop_reg   <= 1'b0;
        end else begin
            wr_en_reg      <= 1'b0;
            scan_valid_reg <= 1'b0;
            scan_done_reg  <= 1'b0;
            // In IDLE a clear or scan request always wins, so any log alongside it is lost.
            log_drop_reg   <= log_req && ((state_reg != IDLE) || clear_req || scan_start);
            case (state_reg)
                IDLE: begin
                    if (clear_req) begin
                        state_reg   <= CLEAR;
                        busy_reg    <= 1'b1;
                        wr_ptr_reg  <= '0;
                        count_reg   <= '0;
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= '0;
                        wr_data_reg <= '0;
                    end else if (scan_start) begin
                        if (count_reg == '0) begin
                            scan_done_reg <= 1'b1;
                        end else begin
                            state_reg   <= SCAN;
                            busy_reg    <= 1'b1;
                            scan_n_reg  <= count_reg;
                            idx_reg     <= '0;
                            // Once wrapped, the write pointer sits on the oldest entry.
                            rd_addr_reg <= full ? wr_ptr_reg : '0;
                        end
                    end else if (log_req) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= wr_ptr_reg;
                        wr_data_reg <= log_data;
                        wr_ptr_reg  <= wr_ptr_reg + ADDR_ONE;
                        if (count_reg != CNT_MAX) begin
                            count_reg <= count_reg + CNT_ONE;
                        end
                    end
                end
                SCAN: begin
                    scan_data_reg  <= rd_data;
                    scan_idx_reg   <= idx_reg;
                    scan_valid_reg <= 1'b1;
                    if ({1'b0, idx_reg} == scan_n_reg - CNT_ONE) begin
                        scan_done_reg <= 1'b1;
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        rd_addr_reg   <= '0;
                    end else begin
                        idx_reg     <= idx_reg + ADDR_ONE;
                        rd_addr_reg <= rd_addr_reg + ADDR_ONE;
                    end
                end
                CLEAR: begin
                    if (wr_addr_reg == ADDR_TOP) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= wr_addr_reg + ADDR_ONE;
                        wr_data_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule
